// File: rtl/instr_sequencer.sv
// Purpose : broadcast instruction sequencer; runs a 16-bit program from local memory,
//           issues normal words to the cores and interprets WAIT/END control words.
// Ports   : clk/reset (sync, active-high); prog_we/prog_addr/prog_data load program
//           memory (IDLE only); glob_we/glob_addr/glob_data write 16 global registers
//           (any state); start/stop control; opcode/execute broadcast; busy; done pulse.
module instr_sequencer #(
  parameter int BIT_WIDTH  = 8,
  parameter int PROG_DEPTH = 32,
  localparam int PA        = $clog2(PROG_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    prog_we,
  input  logic [PA-1:0]           prog_addr,
  input  logic [15:0]             prog_data,
  input  logic                    glob_we,
  input  logic [3:0]              glob_addr,
  input  logic [BIT_WIDTH-1:0]    glob_data,
  input  logic                    start,
  input  logic                    stop,
  output logic [15:0]             opcode,
  output logic                    execute,
  output logic [16*BIT_WIDTH-1:0] global_registers_out,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]           state;
  logic [PA-1:0]        pc;         // address of the word held in fdat
  logic [PA-1:0]        pc_inc;
  logic [3:0]           cnt;
  logic [15:0]          fdat;       // prefetched word at address pc
  logic                 fvld;       // fdat holds mem[pc]; clear only on the first RUN cycle
  logic                 wait_last;  // current WAIT was fetched from the last address
  logic [15:0]          mem [PROG_DEPTH];
  logic [BIT_WIDTH-1:0] glob [16];

  logic is_ctrl;
  logic is_end;
  logic pc_last;

  assign pc_inc  = pc + {{(PA-1){1'b0}}, 1'b1};
  assign is_ctrl = (fdat[15:14] == 2'b11) && fdat[7];
  assign is_end  = is_ctrl && fdat[6];
  assign pc_last = &pc;
  assign busy    = (state != ST_IDLE);

  // Program memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (prog_we && (state == ST_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < 16; g++) begin
        glob[g] <= '0;
      end
    end else if (glob_we) begin
      glob[glob_addr] <= glob_data;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign global_registers_out[BIT_WIDTH*g +: BIT_WIDTH] = glob[g];
  end

  // Sequencer. The word at pc is prefetched into fdat so that the edge ending a
  // WAIT can issue the next word directly; this makes the bubble exactly cnt+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      cnt       <= '0;
      fdat      <= '0;
      fvld      <= 1'b0;
      wait_last <= 1'b0;
      opcode    <= '0;
      execute   <= 1'b0;
      done      <= 1'b0;
    end else begin
      execute <= 1'b0;
      done    <= 1'b0;
      if (state == ST_IDLE) begin
        if (start && !stop) begin
          state <= ST_RUN;
          pc    <= '0;
          fvld  <= 1'b0;
        end
      end else if ((state != ST_RUN) && (state != ST_WAIT)) begin
        state <= ST_IDLE;
        pc    <= '0;
        fvld  <= 1'b0;
      end else if (stop) begin
        state <= ST_IDLE;
        pc    <= '0;
        fvld  <= 1'b0;
      end else if ((state == ST_RUN) && !fvld) begin
        fdat <= mem[pc];
        fvld <= 1'b1;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end else if ((state == ST_WAIT) && wait_last) begin
        // WAIT at the final address: program completes once the bubble ends.
        done  <= 1'b1;
        state <= ST_IDLE;
        pc    <= '0;
        fvld  <= 1'b0;
      end else if (!is_ctrl) begin
        opcode  <= fdat;
        execute <= 1'b1;
        if (pc_last) begin
          done  <= 1'b1;
          state <= ST_IDLE;
          pc    <= '0;
          fvld  <= 1'b0;
        end else begin
          state <= ST_RUN;
          pc    <= pc_inc;
          fdat  <= mem[pc_inc];
        end
      end else if (is_end) begin
        done  <= 1'b1;
        state <= ST_IDLE;
        pc    <= '0;
        fvld  <= 1'b0;
      end else begin
        state     <= ST_WAIT;
        cnt       <= fdat[3:0];
        wait_last <= pc_last;
        pc        <= pc_inc;
        fdat      <= mem[pc_inc];
      end
    end
  end

endmodule
